mcu_spi_packet_tx: RTL

- Parametrised successor to the single-sensor MCU SPI slave.
- Captures raw quaternion and gyro data from NUM_SENSORS BNO085 controllers and commits each update as a packet snapshot into a DEPTH-entry packet FIFO.
- Streams packets to the MCU (SPI master) in mode 0 using the done/load handshake.
- Adds sequence numbering, overflow reporting, a checksum and abort accounting; sck and load are oversampled in the clk domain.

---
 rtl/mcu_spi_packet_tx.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mcu_spi_packet_tx.sv
// Multi-sensor BNO085 snapshot packetiser with a packet FIFO and a mode-0 SPI slave transmitter.
// Optional feature macro: MCU_SPI_TIMESTAMP_EN adds a 2-byte commit timestamp after the status byte.
module mcu_spi_packet_tx #(
  parameter int         NUM_SENSORS = 2,
  parameter int         DEPTH       = 4,
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         TS_SHIFT    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sck,
  input  logic                          load,
  output logic                          sdo,
  output logic                          done,
  input  logic [NUM_SENSORS-1:0]        quat_valid,
  input  logic [16*NUM_SENSORS-1:0]     quat_w,
  input  logic [16*NUM_SENSORS-1:0]     quat_x,
  input  logic [16*NUM_SENSORS-1:0]     quat_y,
  input  logic [16*NUM_SENSORS-1:0]     quat_z,
  input  logic [NUM_SENSORS-1:0]        gyro_valid,
  input  logic [16*NUM_SENSORS-1:0]     gyro_x,
  input  logic [16*NUM_SENSORS-1:0]     gyro_y,
  input  logic [16*NUM_SENSORS-1:0]     gyro_z,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic [7:0]                    overflow_count,
  output logic [7:0]                    abort_count
);

`ifdef MCU_SPI_TIMESTAMP_EN
  localparam int HDR_BYTES = 5;
`else
  localparam int HDR_BYTES = 3;
`endif
  localparam int PKT_BYTES = HDR_BYTES + 1 + 15 * NUM_SENSORS;
  localparam int PKT_BITS  = 8 * PKT_BYTES;
  localparam int AW        = $clog2(DEPTH);
  localparam int BCW       = $clog2(PKT_BITS + 1);

  localparam logic [BCW-1:0] BITS_TOTAL = BCW'(PKT_BITS);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(PKT_BITS - 1);
  localparam logic [AW:0]    FULL_LVL   = (AW + 1)'(DEPTH);

  if (NUM_SENSORS < 1 || NUM_SENSORS > 4 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || TS_SHIFT < 0) begin : g_param_check
    $error("mcu_spi_packet_tx: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DRAIN} tx_state_t;

  // ---------------------------------------------------------------- synchronisers
  logic sck_meta, sck_s, sck_d;
  logic load_meta, load_s, load_d;
  logic sck_rise, sck_fall, load_rise, load_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta  <= 1'b0;
      sck_s     <= 1'b0;
      sck_d     <= 1'b0;
      load_meta <= 1'b0;
      load_s    <= 1'b0;
      load_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
      sck_meta  <= sck;
      sck_s     <= sck_meta;
      sck_d     <= sck_s;
      load_meta <= load;
      load_s    <= load_meta;
      load_d    <= load_s;
    end
  end

  assign sck_rise  =  sck_s & ~sck_d;
  assign sck_fall  = ~sck_s &  sck_d;
  assign load_rise =  load_s & ~load_d;
  assign load_fall = ~load_s &  load_d;

  // ---------------------------------------------------------------- staging
  logic [NUM_SENSORS-1:0][6:0][15:0] stg;
  logic [NUM_SENSORS-1:0]            qflag, gflag;
  logic                              commit_pend;
  logic [7:0]                        seq;
  logic                              sticky_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg         <= '0;
      qflag       <= '0;
      gflag       <= '0;
      commit_pend <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (quat_valid[i]) begin
          stg[i][0] <= quat_w[16*i +: 16];
          stg[i][1] <= quat_x[16*i +: 16];
          stg[i][2] <= quat_y[16*i +: 16];
          stg[i][3] <= quat_z[16*i +: 16];
        end
        if (gyro_valid[i]) begin
          stg[i][4] <= gyro_x[16*i +: 16];
          stg[i][5] <= gyro_y[16*i +: 16];
          stg[i][6] <= gyro_z[16*i +: 16];
        end
      end
      // Valids landing in the commit cycle survive the clear and start the next snapshot.
      qflag       <= (commit_pend ? '0 : qflag) | quat_valid;
      gflag       <= (commit_pend ? '0 : gflag) | gyro_valid;
      commit_pend <= |{quat_valid, gyro_valid};
    end
  end

`ifdef MCU_SPI_TIMESTAMP_EN
  logic [TS_SHIFT+15:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // ---------------------------------------------------------------- packet assembly
  logic [7:0]          pkt_byte [PKT_BYTES];
  logic [7:0]          csum;
  logic [PKT_BITS-1:0] pkt;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    for (int b = 0; b < PKT_BYTES; b++) pkt_byte[b] = 8'h00;
    csum = 8'h00;
    pkt  = '0;
    pkt_byte[0] = HEADER;
    pkt_byte[1] = seq;
    pkt_byte[2] = {7'b0, sticky_ovf};
`ifdef MCU_SPI_TIMESTAMP_EN
    pkt_byte[3] = ts_cnt[TS_SHIFT+15 -: 8];
    pkt_byte[4] = ts_cnt[TS_SHIFT+7 -: 8];
`endif
    for (int i = 0; i < NUM_SENSORS; i++) begin
      for (int f = 0; f < 7; f++) begin
        pkt_byte[HDR_BYTES + 15*i + 2*f]     = stg[i][f][15:8];
        pkt_byte[HDR_BYTES + 15*i + 2*f + 1] = stg[i][f][7:0];
      end
      pkt_byte[HDR_BYTES + 15*i + 14] = {6'b0, gflag[i], qflag[i]};
    end
    for (int b = 0; b < PKT_BYTES - 1; b++) csum = csum ^ pkt_byte[b];
    pkt_byte[PKT_BYTES-1] = csum;
    for (int b = 0; b < PKT_BYTES; b++) pkt[PKT_BITS-1-8*b -: 8] = pkt_byte[b];
  end

  // ---------------------------------------------------------------- packet FIFO
  logic [PKT_BITS-1:0] mem [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                fifo_full, fifo_empty;
  logic                pop, push, drop;
  logic [PKT_BITS-1:0] head;

  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_level == FULL_LVL);
  assign fifo_empty = (fifo_level == '0);
  assign push       = commit_pend & (~fifo_full | pop);
  assign drop       = commit_pend & fifo_full & ~pop;
  assign head       = mem[rd_ptr[AW-1:0]];

  // NOTE: the packet storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      seq            <= 8'h00;
      sticky_ovf     <= 1'b0;
      overflow_count <= 8'h00;
      done           <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (commit_pend) seq <= seq + 8'd1;
      if (drop) begin
        sticky_ovf <= 1'b1;
        if (overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
      end else if (push) begin
        sticky_ovf <= 1'b0;
      end
      done <= ~fifo_empty & ~load_s;
    end
  end

  // ---------------------------------------------------------------- transmitter
  tx_state_t           state, state_next;
  logic [BCW-1:0]      bit_cnt;
  logic [PKT_BITS-2:0] shift_reg;
  logic                abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    abort_hit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load_rise) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_SHIFT;
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_SHIFT: begin
        if (load_fall) begin
          abort_hit  = (bit_cnt < BITS_TOTAL);
          state_next = ST_IDLE;
        end else if (sck_rise && bit_cnt == LAST_BIT) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (load_fall) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo         <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      abort_count <= 8'h00;
    end else begin
      if (abort_hit && abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
      if (pop) begin
        sdo       <= head[PKT_BITS-1];
        shift_reg <= head[PKT_BITS-2:0];
        bit_cnt   <= '0;
      end else if (state == ST_SHIFT && !load_fall) begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) sdo <= 1'b0;
        end else if (sck_fall) begin
          sdo       <= shift_reg[PKT_BITS-2];
          shift_reg <= {shift_reg[PKT_BITS-3:0], 1'b0};
        end
      end else begin
        sdo <= 1'b0;
      end
    end
  end

endmodule
